// File: rtl/ycr_dmem_wb_sram_pkg.sv
// Shared constants for the DMEM SRAM Wishbone slave: bus width, the default
// data-memory SRAM window, and the window decode helper.
package ycr_dmem_wb_sram_pkg;

    // Wishbone data/address width shared by the DMEM path.
    localparam int YCR_WB_WIDTH = 32;

    // Default placement of the DMEM SRAM window (2 KB at 0x0C00_0000).
    localparam logic [YCR_WB_WIDTH-1:0] YCR_DMEM_SRAM_BASE = 32'h0C00_0000;
    localparam logic [YCR_WB_WIDTH-1:0] YCR_DMEM_SRAM_MASK = 32'hFFFF_F800;

    // True when a byte address falls inside the window described by base/mask.
    function automatic logic addr_hit(
        input logic [YCR_WB_WIDTH-1:0] adr,
        input logic [YCR_WB_WIDTH-1:0] base,
        input logic [YCR_WB_WIDTH-1:0] mask
    );
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/ycr_dmem_wb_sram_if.sv
// Wishbone request/response bundle between the core-side DMEM bridge
// (master) and the SRAM slave.
interface ycr_dmem_wb_sram_if;
    import ycr_dmem_wb_sram_pkg::*;

    logic                    wbd_stb_i;
    logic [YCR_WB_WIDTH-1:0] wbd_adr_i;
    logic                    wbd_we_i;
    logic [YCR_WB_WIDTH-1:0] wbd_dat_i;
    logic [3:0]              wbd_sel_i;
    logic [YCR_WB_WIDTH-1:0] wbd_dat_o;
    logic                    wbd_ack_o;
    logic                    wbd_err_o;

    modport master (
        output wbd_stb_i, wbd_adr_i, wbd_we_i, wbd_dat_i, wbd_sel_i,
        input  wbd_dat_o, wbd_ack_o, wbd_err_o
    );

    modport slave (
        input  wbd_stb_i, wbd_adr_i, wbd_we_i, wbd_dat_i, wbd_sel_i,
        output wbd_dat_o, wbd_ack_o, wbd_err_o
    );

endinterface

// File: rtl/ycr_dmem_wb_sram.sv
// DMEM Wishbone slave in front of a single-port SRAM macro. One request is
// served at a time; writes and out-of-window accesses ack one clock after
// acceptance, reads ack RD_LAT+1 clocks after acceptance.
module ycr_dmem_wb_sram
    import ycr_dmem_wb_sram_pkg::*;
#(
    parameter int                      AW        = 9,
    parameter logic [YCR_WB_WIDTH-1:0] BASE_ADDR = YCR_DMEM_SRAM_BASE,
    parameter logic [YCR_WB_WIDTH-1:0] ADDR_MASK = YCR_DMEM_SRAM_MASK,
    parameter int                      RD_LAT    = 1
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    ycr_dmem_wb_sram_if.slave       wbd,
    output logic                    sram_csb,
    output logic                    sram_web,
    output logic [3:0]              sram_wmask,
    output logic [AW-1:0]           sram_addr,
    output logic [YCR_WB_WIDTH-1:0] sram_din,
    input  logic [YCR_WB_WIDTH-1:0] sram_dout
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ACK
    } state_t;

    // Counter preload: the counter reaches zero on the cycle sram_dout is valid.
    localparam logic [1:0] RD_CNT_LOAD = 2'(RD_LAT - 1);

    state_t                  state;
    logic [1:0]              rd_cnt;
    logic                    ack_q;
    logic                    err_q;
    logic [YCR_WB_WIDTH-1:0] dat_q;

    logic                    hit;
    logic [AW-1:0]           word_addr;

    assign hit       = addr_hit(wbd.wbd_adr_i, BASE_ADDR, ADDR_MASK);
    assign word_addr = wbd.wbd_adr_i[AW+1:2];

    assign wbd.wbd_ack_o = ack_q;
    assign wbd.wbd_err_o = err_q;
    assign wbd.wbd_dat_o = dat_q;

    // SRAM is touched only in the IDLE cycle that accepts an in-window request,
    // so a strobe still high during ACK or RD_WAIT never reaches the macro.
    always_comb begin
        sram_csb   = 1'b1;
        sram_web   = 1'b1;
        sram_wmask = '0;
        sram_addr  = '0;
        sram_din   = '0;
        if (!wb_rst && state == IDLE && wbd.wbd_stb_i && hit) begin
            sram_csb  = 1'b0;
            sram_addr = word_addr;
            if (wbd.wbd_we_i) begin
                sram_web   = 1'b0;
                sram_wmask = wbd.wbd_sel_i;
                sram_din   = wbd.wbd_dat_i;
            end
        end
    end

    // Request FSM with registered ack/err/data; reset aborts any read in flight.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state  <= IDLE;
            rd_cnt <= '0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    dat_q <= '0;
                    if (wbd.wbd_stb_i) begin
                        if (!hit) begin
                            ack_q <= 1'b1;
                            err_q <= 1'b1;
                            state <= ACK;
                        end else if (wbd.wbd_we_i) begin
                            ack_q <= 1'b1;
                            state <= ACK;
                        end else begin
                            rd_cnt <= RD_CNT_LOAD;
                            state  <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rd_cnt == 2'd0) begin
                        dat_q <= sram_dout;
                        ack_q <= 1'b1;
                        state <= ACK;
                    end else begin
                        rd_cnt <= rd_cnt - 2'd1;
                    end
                end
                ACK: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    dat_q <= '0;
                    state <= IDLE;
                end
                default: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    dat_q <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
